// File: rtl/sbh_pkg.sv
// Shared types and helpers for the Sign Bit Hiding coefficient-group analyser.
//   state_e        : analyser FSM states (LOAD collects beats, HOLD presents result)
//   sum_w()        : width of a CG abs-sum that cannot overflow
//   SBH_THRESH_DEF : default minimum last/first nonzero distance for hiding
package sbh_pkg;

  typedef enum logic {LOAD = 1'b0, HOLD = 1'b1} state_e;

  localparam int SBH_THRESH_DEF = 4;

  // Each |coef| fits in coeff_w unsigned bits; cg_size of them need log2 more.
  function automatic int sum_w(input int coeff_w, input int cg_size);
    return coeff_w + $clog2(cg_size);
  endfunction

endpackage

// File: rtl/sbh_lane_scan.sv
// Combinational per-beat scan of LANES coefficients.
//   coef_i   : LANES signed coefficients, lane k in coef_i[k]
//   sum_o    : sum of |coef| over the beat (unsigned, no wrap on most-negative)
//   any_nz_o : at least one lane nonzero
//   lo_o     : lowest nonzero lane index (0 when none)
//   hi_o     : highest nonzero lane index (0 when none)
module sbh_lane_scan #(
  parameter int COEFF_W = 16,
  parameter int LANES   = 1,
  parameter int LSUM_W  = COEFF_W + $clog2(LANES),
  parameter int LIDX_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES-1:0][COEFF_W-1:0] coef_i,
  output logic [LSUM_W-1:0]             sum_o,
  output logic                          any_nz_o,
  output logic [LIDX_W-1:0]             lo_o,
  output logic [LIDX_W-1:0]             hi_o
);

  logic [COEFF_W-1:0] mag;

  always_comb begin
    sum_o    = '0;
    any_nz_o = 1'b0;
    lo_o     = '0;
    hi_o     = '0;
    mag      = '0;
    // Magnitude is taken as unsigned, so -2^(W-1) maps to 2^(W-1).
    for (int k = 0; k < LANES; k++) begin
      mag   = coef_i[k][COEFF_W-1] ? (~coef_i[k] + COEFF_W'(1)) : coef_i[k];
      sum_o = sum_o + LSUM_W'(mag);
      if (|coef_i[k]) begin
        any_nz_o = 1'b1;
        hi_o     = LIDX_W'(k);   // last hit wins -> highest lane
      end
    end
    for (int k = LANES - 1; k >= 0; k--) begin
      if (|coef_i[k]) lo_o = LIDX_W'(k);   // last hit wins -> lowest lane
    end
  end

endmodule

// File: rtl/sbh_cg_analyzer.sv
// Coefficient-group analyser feeding SBH parity adjust. Accepts one CG in scan
// order, LANES coefficients per beat, and reports abs-sum, parity, first/last
// nonzero scan position and an all-zero flag.
// Optional macro SBH_CG_ANALYZER_FLAG_EN adds the sign-hiding eligibility flag;
// without it sbh_en is tied low and no distance logic is built.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : beat handshake, in_coef lane k = scan pos beat*LANES+k
//   out_valid/out_ready  : result handshake, result held until accepted
//   abs_sum, parity      : sum of |coef| over CG and its LSB
//   first_nz, last_nz    : lowest/highest nonzero scan index (0 for all-zero CG)
//   all_zero, sbh_en     : no nonzero coefficient / hiding eligible
module sbh_cg_analyzer
  import sbh_pkg::*;
#(
  parameter int  COEFF_W    = 16,
  parameter int  CG_SIZE    = 16,
  parameter int  LANES      = 1,
  parameter int  SBH_THRESH = SBH_THRESH_DEF,
  localparam int IDX_W      = $clog2(CG_SIZE),
  localparam int SUM_W      = sum_w(COEFF_W, CG_SIZE),
  localparam int BEATS      = CG_SIZE / LANES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*COEFF_W-1:0] in_coef,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SUM_W-1:0]         abs_sum,
  output logic                     parity,
  output logic [IDX_W-1:0]         first_nz,
  output logic [IDX_W-1:0]         last_nz,
  output logic                     all_zero,
  output logic                     sbh_en
);

  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int LSUM_W = COEFF_W + $clog2(LANES);

  if (LANES < 1 || (CG_SIZE % LANES) != 0 || CG_SIZE < 4 || SBH_THRESH < 0) begin : g_param_err
    $error("sbh_cg_analyzer: illegal parameter combination");
  end

  state_e             state_q;
  logic [BCNT_W-1:0]  beat_cnt_q;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   first_q, first_d, last_q, last_d;
  logic               seen_nz_n_q, seen_nz_n_d;
  logic [SUM_W-1:0]   abs_sum_q;
  logic [IDX_W-1:0]   first_nz_q, last_nz_q;
  logic               all_zero_q;

  logic [LSUM_W-1:0]  lane_sum;
  logic               lane_any;
  logic [LIDX_W-1:0]  lane_lo, lane_hi;
  logic [IDX_W-1:0]   beat_base;
  logic               accept, last_beat;

  sbh_lane_scan #(.COEFF_W(COEFF_W), .LANES(LANES), .LSUM_W(LSUM_W), .LIDX_W(LIDX_W)) u_scan (
    .coef_i   (in_coef),
    .sum_o    (lane_sum),
    .any_nz_o (lane_any),
    .lo_o     (lane_lo),
    .hi_o     (lane_hi)
  );

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_cnt_q == BCNT_W'(BEATS - 1));

  // Running values including the current beat; on the final beat these are the result.
  always_comb begin
    beat_base   = IDX_W'(int'(beat_cnt_q) * LANES);
    acc_d       = acc_q + SUM_W'(lane_sum);
    first_d     = first_q;
    last_d      = last_q;
    seen_nz_n_d = seen_nz_n_q;
    if (lane_any) begin
      if (seen_nz_n_q) first_d = beat_base + IDX_W'(lane_lo);
      last_d      = beat_base + IDX_W'(lane_hi);
      seen_nz_n_d = 1'b0;
    end
  end

`ifdef SBH_CG_ANALYZER_FLAG_EN
  logic sbh_en_q, sbh_en_d;
  assign sbh_en_d = !seen_nz_n_d && ((int'(last_d) - int'(first_d)) >= SBH_THRESH);
  assign sbh_en   = sbh_en_q;
  always_ff @(posedge clk) begin
    if (rst)                      sbh_en_q <= 1'b0;
    else if (accept && last_beat) sbh_en_q <= sbh_en_d;
  end
`else
  assign sbh_en = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      beat_cnt_q  <= '0;
      acc_q       <= '0;
      first_q     <= '0;
      last_q      <= '0;
      seen_nz_n_q <= 1'b1;
      abs_sum_q   <= '0;
      first_nz_q  <= '0;
      last_nz_q   <= '0;
      all_zero_q  <= 1'b1;
    end else begin
      case (state_q)
        LOAD: if (accept) begin
          acc_q       <= acc_d;
          first_q     <= first_d;
          last_q      <= last_d;
          seen_nz_n_q <= seen_nz_n_d;
          if (last_beat) begin
            abs_sum_q  <= acc_d;
            first_nz_q <= first_d;
            last_nz_q  <= last_d;
            all_zero_q <= seen_nz_n_d;
            beat_cnt_q <= '0;
            state_q    <= HOLD;
          end else begin
            beat_cnt_q <= beat_cnt_q + BCNT_W'(1);
          end
        end
        HOLD: if (out_ready) begin
          acc_q       <= '0;
          first_q     <= '0;
          last_q      <= '0;
          seen_nz_n_q <= 1'b1;
          state_q     <= LOAD;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign abs_sum  = abs_sum_q;
  assign parity   = abs_sum_q[0];
  assign first_nz = first_nz_q;
  assign last_nz  = last_nz_q;
  assign all_zero = all_zero_q;

endmodule

// File: tb/tb_sbh_cg_analyzer.sv
// Directed bench: one LANES=1 and one LANES=4 analyser (CG_SIZE=16) sharing clk/rst.
module tb_sbh_cg_analyzer;

`ifdef SBH_CG_ANALYZER_FLAG_EN
  localparam bit FLAG = 1'b1;
`else
  localparam bit FLAG = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic v1 = 0, r1, ov1, or1 = 0, p1, az1, sb1;
  logic [15:0] c1 = '0;
  logic [19:0] s1;
  logic [3:0]  f1, l1;

  logic v4 = 0, r4, ov4, or4 = 0, p4, az4, sb4;
  logic [63:0] c4 = '0;
  logic [19:0] s4;
  logic [3:0]  f4, l4;

  sbh_cg_analyzer #(.COEFF_W(16), .CG_SIZE(16), .LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_coef(c1),
    .out_valid(ov1), .out_ready(or1), .abs_sum(s1), .parity(p1),
    .first_nz(f1), .last_nz(l1), .all_zero(az1), .sbh_en(sb1));

  sbh_cg_analyzer #(.COEFF_W(16), .CG_SIZE(16), .LANES(4)) u_l4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .in_coef(c4),
    .out_valid(ov4), .out_ready(or4), .abs_sum(s4), .parity(p4),
    .first_nz(f4), .last_nz(l4), .all_zero(az4), .sbh_en(sb4));

  int n_tests = 0, n_fail = 0;
  int cg[16];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Full result check on one DUT at a negedge.
  task automatic chk_res(input bit sel, input string tag, input int sum, input int first,
                         input int last, input bit az, input bit sbh);
    chk({tag, ".ov"},   sel ? ov4 : ov1, 1);
    chk({tag, ".rdy"},  sel ? r4 : r1, 0);
    chk({tag, ".sum"},  sel ? s4 : s1, sum);
    chk({tag, ".par"},  sel ? p4 : p1, sum % 2);
    chk({tag, ".first"}, sel ? f4 : f1, first);
    chk({tag, ".last"}, sel ? l4 : l1, last);
    chk({tag, ".az"},   sel ? az4 : az1, az);
    chk({tag, ".sbh"},  sel ? sb4 : sb1, sbh);
  endtask

  // Drive cg[] into the selected DUT; returns at the negedge after the final beat.
  task automatic send(input bit sel, input bit gaps);
    int beats = sel ? 4 : 16;
    int b = 0;
    while (b < beats) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        if (sel) begin v4 = 0; c4 = {$urandom, $urandom}; end
        else     begin v1 = 0; c1 = 16'($urandom); end
        @(posedge clk);
      end else begin
        if (b == beats - 1 && !gaps) chk("pre_final.ov", sel ? ov4 : ov1, 0);
        if (sel) begin
          v4 = 1;
          for (int k = 0; k < 4; k++) c4[k*16 +: 16] = 16'(cg[b*4+k]);
        end else begin
          v1 = 1; c1 = 16'(cg[b]);
        end
        @(posedge clk);
        b++;
      end
    end
    @(negedge clk);
    v1 = 0; v4 = 0;
  endtask

  // Accept the result and confirm the block is ready again on the next cycle.
  task automatic release_out(input bit sel, input string tag);
    if (sel) or4 = 1; else or1 = 1;
    @(posedge clk);
    @(negedge clk);
    or1 = 0; or4 = 0;
    chk({tag, ".rel_rdy"}, sel ? r4 : r1, 1);
    chk({tag, ".rel_ov"},  sel ? ov4 : ov1, 0);
  endtask

  task automatic clr_cg();
    for (int i = 0; i < 16; i++) cg[i] = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst.rdy", r1, 1); chk("rst.ov", ov1, 0); chk("rst.sum", s1, 0);
    chk("rst.par", p1, 0); chk("rst.first", f1, 0); chk("rst.last", l1, 0);
    chk("rst.az", az1, 1); chk("rst.sbh", sb1, 0);
    chk("rst4.rdy", r4, 1); chk("rst4.az", az4, 1);

    // Basic CG, then backpressure for 5 cycles.
    clr_cg(); cg[2] = 3; cg[4] = -2; cg[7] = 5;
    send(0, 0);
    chk_res(0, "basic", 10, 2, 7, 0, FLAG);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      chk_res(0, "bp", 10, 2, 7, 0, FLAG);
    end
    release_out(0, "basic");

    clr_cg();
    send(0, 0);
    chk_res(0, "zero", 0, 0, 0, 1, 0);
    release_out(0, "zero");

    clr_cg(); cg[13] = -32768;
    send(1, 0);
    chk_res(1, "neg", 32768, 13, 13, 0, 0);
    release_out(1, "neg");

    clr_cg(); cg[1] = 1; cg[4] = 1;
    send(1, 0);
    chk_res(1, "dist3", 2, 1, 4, 0, 0);
    release_out(1, "dist3");

    clr_cg(); cg[1] = 1; cg[5] = 1;
    send(1, 0);
    chk_res(1, "dist4", 2, 1, 5, 0, FLAG);
    release_out(1, "dist4");

    clr_cg(); cg[0] = -1; cg[3] = 2; cg[6] = 4; cg[11] = -7;
    send(1, 0);
    chk_res(1, "mix4", 14, 0, 11, 0, FLAG);
    release_out(1, "mix4");

    // Same basic CG with random valid gaps.
    clr_cg(); cg[2] = 3; cg[4] = -2; cg[7] = 5;
    send(0, 1);
    chk_res(0, "gaps", 10, 2, 7, 0, FLAG);
    release_out(0, "gaps");

    clr_cg(); cg[1] = 1; cg[5] = 1;
    send(1, 1);
    chk_res(1, "gaps4", 2, 1, 5, 0, FLAG);
    release_out(1, "gaps4");

    // Reset after 8 of 16 beats, then an all-ones CG.
    for (int b = 0; b < 8; b++) begin
      @(negedge clk); v1 = 1; c1 = 16'd7;
      @(posedge clk);
    end
    @(negedge clk); v1 = 0; rst = 1;
    @(posedge clk);
    @(negedge clk); rst = 0;
    chk("midrst.rdy", r1, 1); chk("midrst.ov", ov1, 0); chk("midrst.az", az1, 1);
    for (int i = 0; i < 16; i++) cg[i] = 1;
    send(0, 0);
    chk_res(0, "ones", 16, 0, 15, 0, FLAG);
    release_out(0, "ones");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
